// File: rtl/radix2_div_if.sv
// Request/response bundle between the execute stage and the iterative divider.
//   master : execute stage, drives the start request and operands, receives results.
//   slave  : divider, samples the request and returns quotient/remainder with status.
interface radix2_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div_en;        // one-cycle start request
  logic             div_signed;    // 1 = DIV, 0 = DIVU
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;      // held until the next result
  logic [WIDTH-1:0] remainder;     // held until the next result
  logic             div_busy;      // high while iterating
  logic             div_complete;  // one-cycle result-valid pulse

  modport master (
    output div_en, div_signed, dividend, divisor,
    input  quotient, remainder, div_busy, div_complete
  );

  modport slave (
    input  div_en, div_signed, dividend, divisor,
    output quotient, remainder, div_busy, div_complete
  );
endinterface

// File: rtl/radix2_div.sv
// Iterative restoring divider for DIV/DIVU. One quotient bit per clock, fixed latency:
// a start accepted on edge N gives div_busy for WIDTH cycles and div_complete one cycle later.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; aborts any operation in flight
//   bus    : radix2_div_if slave (div_en, div_signed, dividend, divisor in;
//            quotient, remainder, div_busy, div_complete out)
module radix2_div #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  radix2_div_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;          // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] dvsr_q, dvsr_d;        // |divisor|
  logic [WIDTH-1:0] dvnd_q, dvnd_d;        // raw dividend, returned on divide-by-zero
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] dvnd_abs, dvsr_abs;
  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] rem_next, quo_next;

  // Magnitudes in two's complement; -2^(W-1) maps onto itself, which is the correct
  // unsigned magnitude.
  assign dvnd_abs = (bus.div_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign dvsr_abs = (bus.div_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // One restoring step; the extra top bit of trial is the borrow.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvsr_q};
  assign rem_next  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dvnd_d      = dvnd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.div_en) begin
          state_d    = StCalc;
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = dvnd_abs;
          dvsr_d     = dvsr_abs;
          dvnd_d     = bus.dividend;
          neg_quo_d  = bus.div_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_d  = bus.div_signed && bus.dividend[WIDTH-1];
          div_zero_d = (bus.divisor == '0);
        end
      end
      StCalc: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Results are published on the same edge as the final iteration.
          state_d = StDone;
          if (div_zero_q) begin
            quotient_d  = '1;
            remainder_d = dvnd_q;
          end else begin
            quotient_d  = neg_quo_q ? -quo_next : quo_next;
            remainder_d = neg_rem_q ? -rem_next : rem_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dvnd_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      dvnd_q      <= dvnd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;
  assign bus.div_busy     = (state_q == StCalc);
  assign bus.div_complete = (state_q == StDone);

endmodule

// File: tb/tb_radix2_div.sv
// Scoreboard bench for radix2_div: expected results are queued when an operation is
// driven and compared when div_complete is seen.
module tb_radix2_div;
  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    int unsigned      cyc;  // cycle count at which div_complete must be observed
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done = 0;
  int          n_pushed = 0;
  int          busy_cnt = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  radix2_div_if #(.WIDTH(WIDTH)) bus ();

  radix2_div #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference built from native 64-bit arithmetic (truncating division).
  function automatic exp_t model(input bit sgn, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t   e;
    longint sa, sb, lq, lr;
    e.cyc = 0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (!sgn) begin
      e.q = a / b;
      e.r = a % b;
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lq  = sa / sb;
      lr  = sa % sb;
      e.q = lq[WIDTH-1:0];
      e.r = lr[WIDTH-1:0];
    end
    return e;
  endfunction

  // Drive a request in the current (negedge) timestep and release it one cycle later.
  task automatic drive_now(input bit sgn, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    exp_t e;
    bus.div_en     = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    e     = model(sgn, a, b);
    e.cyc = cyc + 1 + WIDTH;
    exp_q.push_back(e);
    n_pushed++;
    @(negedge clk);
    bus.div_en     = 1'b0;
    bus.div_signed = 1'($urandom);
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
  endtask

  task automatic start_op(input bit sgn, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    @(negedge clk);
    drive_now(sgn, a, b);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: count busy cycles per operation and score each completion.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.div_busy) busy_cnt++;
      if (bus.div_complete) begin
        if (exp_q.size() == 0) begin
          check("unexpected_complete", 64'(bus.div_complete), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("quotient", 64'(bus.quotient), 64'(e.q));
          check("remainder", 64'(bus.remainder), 64'(e.r));
          check("latency", 64'(cyc), 64'(e.cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
          check("busy_in_done", 64'(bus.div_busy), 64'd0);
          n_done++;
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    bus.div_en     = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_busy", 64'(bus.div_busy), 64'd0);
    check("rst_complete", 64'(bus.div_complete), 64'd0);
    reset = 1'b0;

    // Directed cases: plain, signed mixes, overflow wrap, divide by zero.
    start_op(1'b0, 32'd100, 32'd7);               wait_drained();
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);         wait_drained();
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE);         wait_drained();
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_drained();
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_drained();
    start_op(1'b0, 32'h0000_1234, 32'd0);         wait_drained();
    start_op(1'b1, 32'h0000_1234, 32'd0);         wait_drained();
    start_op(1'b1, 32'hFFFF_FF00, 32'd0);         wait_drained();

    // Random operands; divisors of varied magnitude.
    for (int i = 0; i < 8; i++) begin
      start_op((i % 2) == 1, $urandom, $urandom >> $urandom_range(0, 31));
      wait_drained();
    end

    // div_en during CALC is ignored; div_en in DONE starts back-to-back.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    bus.div_en = 1'b1; bus.dividend = 32'd55; bus.divisor = 32'd5;
    @(negedge clk);
    bus.div_en = 1'b0;
    repeat (14) @(negedge clk);
    bus.div_en = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd9;
    @(negedge clk);
    bus.div_en = 1'b0;
    for (int i = 0; i < 100 && !bus.div_complete; i++) @(negedge clk);
    check("first_complete_seen", 64'(bus.div_complete), 64'd1);
    drive_now(1'b1, 32'hFFFF_FF9C, 32'd7);  // -100 / 7
    wait_drained();
    check("complete_count", 64'(n_done), 64'(n_pushed));

    // Reset mid-operation: outputs clear immediately and the op never completes.
    start_op(1'b0, 32'hDEAD_BEEF, 32'd13);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_quotient", 64'(bus.quotient), 64'd0);
    check("abort_remainder", 64'(bus.remainder), 64'd0);
    check("abort_busy", 64'(bus.div_busy), 64'd0);
    check("abort_complete", 64'(bus.div_complete), 64'd0);
    exp_q.delete();
    n_pushed--;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_complete_after_abort", 64'(n_done), 64'(n_pushed));
    start_op(1'b1, 32'd12345, 32'hFFFF_FFEF);  // 12345 / -17
    wait_drained();
    check("final_complete_count", 64'(n_done), 64'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
